// File: rtl/sqr_sgn_energy_acc_if.sv
// Sample-in / block-energy-out bundle for sqr_sgn_energy_acc.
// master = stream source plus sum consumer; slave = the accumulator.
interface sqr_sgn_energy_acc_if #(
    parameter int width    = 8,
    parameter int accWidth = 2*width+8,
    parameter int lenWidth = 8
);
    logic                       clear_i;
    logic [lenWidth-1:0]        len_i;
    logic                       x_valid_i;
    logic                       x_ready_o;
    logic signed [width-1:0]    x_i;
    logic                       sum_valid_o;
    logic                       sum_ready_i;
    logic [accWidth-1:0]        sum_o;
    logic [lenWidth-1:0]        count_o;
    logic                       ovf_o;

    modport master (
        output clear_i, len_i, x_valid_i, x_i, sum_ready_i,
        input  x_ready_o, sum_valid_o, sum_o, count_o, ovf_o
    );

    modport slave (
        input  clear_i, len_i, x_valid_i, x_i, sum_ready_i,
        output x_ready_o, sum_valid_o, sum_o, count_o, ovf_o
    );
endinterface

// File: rtl/sqr_sgn_energy_acc.sv
// Block energy accumulator: sums X*X over LEN samples using a signed squarer.
// Define SQR_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module SqrSgn #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic signed [width-1:0] x_i,
    output logic [2*width-1:0]      sq_o
);
    localparam int SW = 2*width;

    function automatic int top_pow(input int n);
        int t = 1;
        while (t * 2 < n) t = t * 2;
        return t;
    endfunction

    localparam int BK_TOP = top_pow(SW);

    // speed picks the carry network: 0 ripple, 1 Brent-Kung, 2 Sklansky
    function automatic logic [SW-1:0] add_f(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] p, c, gg, pp;
        logic          rc;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        c  = '0;
        rc = 1'b0;
        if (speed == 0) begin
            for (int i = 0; i < SW; i++) begin
                rc   = gg[i] | (pp[i] & rc);
                c[i] = rc;
            end
        end else begin
            if (speed == 1) begin
                for (int d = 1; d < SW; d = d * 2)
                    for (int i = 2*d-1; i < SW; i = i + 2*d) begin
                        gg[i] = gg[i] | (pp[i] & gg[i-d]);
                        pp[i] = pp[i] & pp[i-d];
                    end
                for (int d = BK_TOP; d >= 1; d = d / 2)
                    for (int i = 3*d-1; i < SW; i = i + 2*d) begin
                        gg[i] = gg[i] | (pp[i] & gg[i-d]);
                        pp[i] = pp[i] & pp[i-d];
                    end
            end else begin
                for (int l = 0; (1 << l) < SW; l++)
                    for (int i = 0; i < SW; i++)
                        if (((i >> l) & 1) == 1) begin
                            gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
                            pp[i] = pp[i] & pp[((i >> l) << l) - 1];
                        end
            end
            c = gg;
        end
        return p ^ (c << 1);
    endfunction

    logic [width-1:0] mag;

    // |x| fits in width bits unsigned, including -2**(width-1)
    always_comb begin
        mag  = x_i[width-1] ? width'(-x_i) : width'(x_i);
        sq_o = '0;
        for (int i = 0; i < width; i++)
            if (mag[i]) sq_o = add_f(sq_o, SW'(mag) << i);
    end
endmodule

module sqr_sgn_energy_acc #(
    parameter int width    = 8,
    parameter int speed    = 2,
    parameter int accWidth = 2*width+8,
    parameter int lenWidth = 8
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    sqr_sgn_energy_acc_if.slave bus
);
    localparam int AW1 = accWidth + 1;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_e;

    state_e                  state_q, state_d;
    logic signed [width-1:0] x_q, x_d;
    logic                    v_q, v_d, last_q, last_d, ovf_q, ovf_d;
    logic [lenWidth-1:0]     len_q, len_d, cnt_q, cnt_d, cnt_inc, len_eff;
    logic [accWidth-1:0]     acc_q, acc_d;
    logic [accWidth:0]       acc_sum;
    logic [2*width-1:0]      sq;
    logic                    x_ready, sum_valid, accept, is_last, sum_hs;

    SqrSgn #(.width(width), .speed(speed)) u_sqr (.x_i(x_q), .sq_o(sq));

    assign accept  = bus.x_valid_i & x_ready;
    assign sum_hs  = sum_valid & bus.sum_ready_i;
    // The first sample of a block compares against len_i before it is latched
    assign len_eff = (state_q == IDLE) ? bus.len_i : len_q;
    assign cnt_inc = cnt_q + lenWidth'(1);
    assign is_last = (cnt_inc == len_eff);
    assign acc_sum = {1'b0, acc_q} + AW1'(sq);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            v_q     <= v_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = is_last ? DRAIN : ACC;
                ACC:     if (accept && is_last) state_d = DRAIN;
                DRAIN:   if (last_q) state_d = OUT;
                OUT:     if (sum_hs) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        x_ready   = (state_q == IDLE) || (state_q == ACC);
        sum_valid = (state_q == OUT);
    end

    always_comb begin
        x_d    = x_q;
        v_d    = accept;
        last_d = accept & is_last;
        len_d  = (state_q == IDLE && accept) ? bus.len_i : len_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (accept) begin
            x_d   = bus.x_i;
            cnt_d = cnt_inc;
        end
        if (v_q) begin
            acc_d = acc_sum[accWidth-1:0];
            ovf_d = ovf_q | acc_sum[accWidth];
`ifdef SQR_ACC_SAT_EN
            if (ovf_d) acc_d = '1;
`endif
        end
        if (sum_hs) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
        // Abort wins over any handshake in the same cycle
        if (bus.clear_i) begin
            v_d    = 1'b0;
            last_d = 1'b0;
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end
    end

    assign bus.x_ready_o   = x_ready;
    assign bus.sum_valid_o = sum_valid;
    assign bus.sum_o       = acc_q;
    assign bus.count_o     = cnt_q;
    assign bus.ovf_o       = ovf_q;
endmodule
